// File: rtl/cellular_ram_responder_if.sv
// Controller <-> responder control/address signals of the CellularRAM burst protocol.
// The ramData bus stays a plain inout port on the responder.
interface cellular_ram_responder_if #(
  parameter int ADDRESS_SIZE = 24
) ();
  logic [ADDRESS_SIZE-1:0] ramAddress;
  logic                    lowerByte;
  logic                    upperByte;
  logic                    outputEnable;
  logic                    writeEnable;
  logic                    mt_clk;
  logic                    mt_adv;
  logic                    mt_ce;
  logic                    mt_cre;
  logic                    mt_wait;

  modport master (
    output ramAddress, lowerByte, upperByte, outputEnable, writeEnable,
    output mt_clk, mt_adv, mt_ce, mt_cre,
    input  mt_wait
  );

  modport slave (
    input  ramAddress, lowerByte, upperByte, outputEnable, writeEnable,
    input  mt_clk, mt_adv, mt_ce, mt_cre,
    output mt_wait
  );
endinterface

// File: rtl/cellular_ram_responder.sv
// Behavioural CellularRAM burst responder: config register, latency countdown, burst read/write.
// Define RAM_RESPONDER_WAIT_EN to drive mt_wait during latency; otherwise mt_wait is tied low.
module cellular_ram_responder #(
  parameter int ADDRESS_SIZE = 24,
  parameter int DATA_SIZE    = 16,
  parameter int MEM_AW       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire  [DATA_SIZE-1:0] ramData,
  cellular_ram_responder_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LATENCY = 2'd1;
  localparam logic [1:0] READ    = 2'd2;
  localparam logic [1:0] WRITE   = 2'd3;
  localparam logic [3:0] LAT_RESET = 4'd3;

  logic [1:0]              state;
  logic [3:0]              lat;
  logic [3:0]              latCnt;
  logic [MEM_AW-1:0]       ptr;
  logic [DATA_SIZE-1:0]    readReg;
  logic                    mtClkPrev;
  logic [DATA_SIZE-1:0]    mem [2**MEM_AW];

  logic [ADDRESS_SIZE-1:0] addr;
  logic                    unusedAddrBits;
  logic                    burstEdge;
  logic                    addrEdge;
  logic                    creEdge;
  logic                    stepEdge;
  logic                    memWe;
  logic                    driveBus;

  assign addr           = bus.ramAddress;
  assign unusedAddrBits = ^addr[ADDRESS_SIZE-1:MEM_AW];

  // A deselected chip ignores burst edges entirely; mt_ce also forces IDLE below.
  assign burstEdge = !mtClkPrev && bus.mt_clk && !bus.mt_ce;
  assign addrEdge  = burstEdge && !bus.mt_adv && !bus.mt_cre;
  assign creEdge   = burstEdge && !bus.mt_adv &&  bus.mt_cre;
  assign stepEdge  = burstEdge &&  bus.mt_adv;

  assign memWe    = !rst && stepEdge && (state == WRITE) && !bus.writeEnable;
  assign driveBus = (state == READ) && !bus.mt_ce && !bus.outputEnable && bus.writeEnable;
  assign ramData  = driveBus ? readReg : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat       <= LAT_RESET;
      latCnt    <= '0;
      ptr       <= '0;
      readReg   <= '0;
      mtClkPrev <= 1'b0;
    end else begin
      mtClkPrev <= bus.mt_clk;
      if (bus.mt_ce) begin
        state <= IDLE;
      end else if (addrEdge) begin
        ptr    <= addr[MEM_AW-1:0];
        latCnt <= lat;
        state  <= LATENCY;
      end else if (creEdge) begin
        if (!bus.writeEnable) begin
          lat   <= addr[3:0];
          state <= IDLE;
        end
      end else if (stepEdge) begin
        case (state)
          // Leaving on the edge that brings the count to zero keeps the wait window LAT edges long;
          // LAT=0 behaves like LAT=1 (first edge after the address).
          LATENCY: begin
            if (latCnt <= 4'd1) state <= bus.writeEnable ? READ : WRITE;
            else                latCnt <= latCnt - 4'd1;
          end
          READ: begin
            readReg <= mem[ptr];
            ptr     <= ptr + MEM_AW'(1);
          end
          WRITE: begin
            if (!bus.writeEnable) ptr <= ptr + MEM_AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Storage is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (memWe) begin
      if (!bus.lowerByte) mem[ptr][7:0]           <= ramData[7:0];
      if (!bus.upperByte) mem[ptr][DATA_SIZE-1:8] <= ramData[DATA_SIZE-1:8];
    end
  end

`ifdef RAM_RESPONDER_WAIT_EN
  logic mtWait;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mtWait <= 1'b0;
    else     mtWait <= (state == LATENCY);
  end
  assign bus.mt_wait = mtWait;
`else
  assign bus.mt_wait = 1'b0;
`endif
endmodule
